array_arbiter: RTL and testbench
================================

Name: array_arbiter

Overview:
Shares the N x N weight-stationary systolic array between NUM_REQ requesters and sequences each granted job through its phases. A job is one matrix tile: load N stationary weight rows, stream `rows` operand rows, then drain the skewed results. The block sits between the requester front-ends and the array controller/feeders, driving their phase enables and row indices. It arbitrates round-robin and admits one job at a time.

Parameters:
N, 4, array dimension (power of 2, >=2)
NUM_REQ, 2, number of requesters (>=2)
ROWS_W, 8, width of the per-job streamed-row count
LOG_N, $clog2(N), width of load_row_o

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
req_valid_i  input  NUM_REQ  per-requester job request
req_rows_i  input  NUM_REQ*ROWS_W  per-requester streamed-row count; requester r occupies bits [r*ROWS_W +: ROWS_W]
req_ready_o  output  NUM_REQ  job accept; a handshake completes on valid&ready at the rising edge
grant_o  output  NUM_REQ  one-hot current array owner
busy_o  output  1  array occupied (state != IDLE)
load_en_o  output  1  LOAD phase active
load_row_o  output  LOG_N  weight row being loaded
stream_en_o  output  1  STREAM phase active
stream_idx_o  output  ROWS_W  operand row being streamed
drain_o  output  1  DRAIN phase active
done_o  output  NUM_REQ  one-cycle completion pulse to the owner

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, rr_ptr=0, all counters 0. All outputs are 0.
- Mid-job reset aborts the job without a done_o pulse. The requester must re-request.
- The FSM has five states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - The winner is the first r with req_valid_i[r]=1, searching r = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready_o is combinational and one-hot: it is set only for the winner, and only in IDLE. It is 0 in every other state.
  - On the handshake edge: latch the winner's rows into rows_q, set grant_o to the winner (onehot), clear the counter, and go to LOAD.
  - With no valid request, stay in IDLE.
- LOAD:
  - Lasts exactly N cycles. load_en_o=1 and load_row_o = 0..N-1.
  - After the last cycle, go to STREAM if rows_q != 0. If rows_q == 0, go directly to DONE, skipping STREAM and DRAIN.
- STREAM:
  - Lasts exactly rows_q cycles. stream_en_o=1 and stream_idx_o = 0..rows_q-1.
  - Then go to DRAIN.
- DRAIN:
  - Lasts exactly 2N-1 cycles to flush the skew. drain_o=1.
  - Then go to DONE.
- DONE:
  - Lasts 1 cycle. done_o = grant_o for that cycle.
  - On exit, rr_ptr = (owner index + 1) mod NUM_REQ. Then go to IDLE.
- grant_o is held from the cycle after acceptance through DONE inclusive. It is 0 in IDLE. It is always one-hot or zero.
- All outputs except req_ready_o are registered or decoded purely from state and counter registers. There is no combinational input-to-output path other than through req_ready_o.
- Counter width is max(ROWS_W, LOG_N+2). No wrap occurs within a phase.
- Job occupancy is N + rows + (2N-1) + 1 cycles when rows > 0, and N + 1 cycles when rows == 0. The next acceptance comes at the earliest one IDLE cycle after DONE.
- Inputs while not in IDLE:
  - req_valid_i and req_rows_i changes are ignored.
  - Pending requests simply wait. There is no queueing beyond the requester holding valid.
- A requester dropping valid before it is granted is legal. It is not granted.
- The maximum rows value 2^ROWS_W-1 must stream fully, with no off-by-one.

Test Plan:
1. Single job, N=4: req0 valid with rows=5 -> ready0 pulses 1 cycle. load_en high 4 cycles (rows 0..3), stream_en 5 cycles (idx 0..4), drain_o 7 cycles, done_o=01 for 1 cycle. busy_o high 17 cycles.
2. Contention: req0 and req1 both valid from reset -> req0 granted first, then req1 next. A third back-to-back req0 follows req1. grant_o is 01, 10, 01 and never overlaps.
3. Zero-length job: rows=0 -> 4 LOAD cycles, then DONE immediately. stream_en_o and drain_o never assert. done_o pulses.
4. Max length: rows=255 -> stream_idx_o runs 0..254 with no wrap, then DRAIN 7 cycles.
5. Mid-STREAM async reset (asserted between clock edges) -> all outputs go to 0 immediately with no done_o. After release, the still-valid requester is re-granted starting from rr_ptr=0.
6. Input stability: change req_rows_i and toggle req_valid_i during LOAD, STREAM and DRAIN -> phase lengths are unchanged and req_ready_o stays 0 throughout.

Source files
------------

// File: rtl/array_arbiter.sv
// array_arbiter: round-robin owner selection for the shared N x N
// weight-stationary systolic array, plus the LOAD / STREAM / DRAIN / DONE
// sequencing of the single job currently admitted to it.
module array_arbiter #(
   parameter int N       = 4,
   parameter int NUM_REQ = 2,
   parameter int ROWS_W  = 8,
   parameter int LOG_N   = $clog2(N)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*ROWS_W-1:0] req_rows_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      busy_o,
   output logic                      load_en_o,
   output logic [LOG_N-1:0]          load_row_o,
   output logic                      stream_en_o,
   output logic [ROWS_W-1:0]         stream_idx_o,
   output logic                      drain_o,
   output logic [NUM_REQ-1:0]        done_o
);

   // The phase counter must hold the largest streamed-row index and the
   // 2N-2 drain index without wrapping.
   localparam int CNT_W = (ROWS_W > LOG_N + 2) ? ROWS_W : LOG_N + 2;
   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * N - 2);
   localparam logic [IDX_W:0]   REQ_COUNT  = (IDX_W + 1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_REQ   = IDX_W'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [ROWS_W-1:0]    rows_q;
   logic [IDX_W-1:0]     owner_q;
   logic [IDX_W-1:0]     rr_ptr_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic                 busy_q;
   logic                 load_en_q;
   logic [LOG_N-1:0]     load_row_q;
   logic                 stream_en_q;
   logic [ROWS_W-1:0]    stream_idx_q;
   logic                 drain_q;
   logic [NUM_REQ-1:0]   done_q;

   logic [ROWS_W-1:0]    req_rows [NUM_REQ];
   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [NUM_REQ-1:0]   win_onehot;
   logic [IDX_W:0]       search_sum;
   logic [IDX_W-1:0]     search_cand;
   logic [CNT_W-1:0]     rows_last;

   // Unpack the flat per-requester row-count bus into one entry per requester.
   always_comb begin
      for (int r = 0; r < NUM_REQ; r++) begin
         req_rows[r] = req_rows_i[r*ROWS_W +: ROWS_W];
      end
   end

   // Round-robin search: first valid requester at or after rr_ptr, modulo NUM_REQ.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      win_found   = 1'b0;
      win_idx     = '0;
      search_sum  = '0;
      search_cand = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         search_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
         if (search_sum >= REQ_COUNT) begin
            search_sum = search_sum - REQ_COUNT;
         end
         search_cand = search_sum[IDX_W-1:0];
         if (!win_found && req_valid_i[search_cand]) begin
            win_found = 1'b1;
            win_idx   = search_cand;
         end
      end
   end

   // One-hot winner and the accept strobe, which is only offered while idle.
   always_comb begin
      win_onehot  = win_found ? (NUM_REQ'(1) << win_idx) : '0;
      req_ready_o = (state_q == ST_IDLE && !rst_i) ? win_onehot : '0;
      rows_last   = CNT_W'(rows_q) - CNT_W'(1);
   end

   // Job sequencer: phase state, phase counter and all registered phase outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rows_q       <= '0;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         load_en_q    <= 1'b0;
         load_row_q   <= '0;
         stream_en_q  <= 1'b0;
         stream_idx_q <= '0;
         drain_q      <= 1'b0;
         done_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every right-hand
         // side sees the value from before this clock edge.
         done_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (win_found) begin
                  state_q    <= ST_LOAD;
                  rows_q     <= req_rows[win_idx];
                  owner_q    <= win_idx;
                  grant_q    <= win_onehot;
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
                  load_en_q  <= 1'b1;
                  load_row_q <= '0;
               end
            end

            ST_LOAD: begin
               if (cnt_q == LOAD_LAST) begin
                  cnt_q      <= '0;
                  load_en_q  <= 1'b0;
                  load_row_q <= '0;
                  if (rows_q != '0) begin
                     state_q      <= ST_STREAM;
                     stream_en_q  <= 1'b1;
                     stream_idx_q <= '0;
                  end else begin
                     // Empty tile: nothing to stream or drain.
                     state_q <= ST_DONE;
                     done_q  <= grant_q;
                  end
               end else begin
                  cnt_q      <= cnt_q + CNT_W'(1);
                  load_row_q <= load_row_q + LOG_N'(1);
               end
            end

            ST_STREAM: begin
               if (cnt_q == rows_last) begin
                  state_q      <= ST_DRAIN;
                  cnt_q        <= '0;
                  stream_en_q  <= 1'b0;
                  stream_idx_q <= '0;
                  drain_q      <= 1'b1;
               end else begin
                  cnt_q        <= cnt_q + CNT_W'(1);
                  stream_idx_q <= stream_idx_q + ROWS_W'(1);
               end
            end

            ST_DRAIN: begin
               if (cnt_q == DRAIN_LAST) begin
                  state_q <= ST_DONE;
                  cnt_q   <= '0;
                  drain_q <= 1'b0;
                  done_q  <= grant_q;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_DONE: begin
               // Priority moves past the requester that just finished.
               state_q  <= ST_IDLE;
               grant_q  <= '0;
               busy_q   <= 1'b0;
               rr_ptr_q <= (owner_q == LAST_REQ) ? '0 : owner_q + IDX_W'(1);
            end

            default: begin
               state_q     <= ST_IDLE;
               cnt_q       <= '0;
               grant_q     <= '0;
               busy_q      <= 1'b0;
               load_en_q   <= 1'b0;
               stream_en_q <= 1'b0;
               drain_q     <= 1'b0;
            end
         endcase
      end
   end

   assign grant_o      = grant_q;
   assign busy_o       = busy_q;
   assign load_en_o    = load_en_q;
   assign load_row_o   = load_row_q;
   assign stream_en_o  = stream_en_q;
   assign stream_idx_o = stream_idx_q;
   assign drain_o      = drain_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_array_arbiter.sv
// tb_array_arbiter: drives array_arbiter with directed and random job
// requests and compares every output each cycle against a job-level model
// (arbitration pointer plus "cycles since acceptance" arithmetic).
module tb_array_arbiter;

   localparam int N  = 4;
   localparam int NR = 2;
   localparam int RW = 8;
   localparam int LN = $clog2(N);

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*RW-1:0]  req_rows;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     grant;
   logic              busy;
   logic              load_en;
   logic [LN-1:0]     load_row;
   logic              stream_en;
   logic [RW-1:0]     stream_idx;
   logic              drain;
   logic [NR-1:0]     done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: job-level view only.
   bit m_busy     = 1'b0;
   int m_owner    = 0;
   int m_rows     = 0;
   int m_k        = 0;
   int m_ptr      = 0;
   bit m_accepted = 1'b0;

   array_arbiter #(
      .N       (N),
      .NUM_REQ (NR),
      .ROWS_W  (RW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_rows_i   (req_rows),
      .req_ready_o  (req_ready),
      .grant_o      (grant),
      .busy_o       (busy),
      .load_en_o    (load_en),
      .load_row_o   (load_row),
      .stream_en_o  (stream_en),
      .stream_idx_o (stream_idx),
      .drain_o      (drain),
      .done_o       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int ptr);
      for (int i = 0; i < NR; i++) begin
         if (v[(ptr + i) % NR]) return (ptr + i) % NR;
      end
      return -1;
   endfunction

   // Offset (cycles after acceptance) of the DONE cycle.
   function automatic int done_offset(input int rows);
      return (rows == 0) ? N : N + rows + 2 * N - 1;
   endfunction

   task automatic compare_all();
      logic [NR-1:0] e_ready;
      logic [NR-1:0] e_grant;
      logic [NR-1:0] e_done;
      logic          e_load;
      logic          e_stream;
      logic          e_drain;
      int            e_lrow;
      int            e_sidx;
      int            w;
      e_ready  = '0;
      e_grant  = '0;
      e_done   = '0;
      e_load   = 1'b0;
      e_stream = 1'b0;
      e_drain  = 1'b0;
      e_lrow   = 0;
      e_sidx   = 0;
      if (!m_busy && !rst) begin
         w = pick(req_valid, m_ptr);
         if (w >= 0) e_ready[w] = 1'b1;
      end
      if (m_busy) begin
         e_grant[m_owner] = 1'b1;
         if (m_k < N) begin
            e_load = 1'b1;
            e_lrow = m_k;
         end else if (m_k < N + m_rows) begin
            e_stream = 1'b1;
            e_sidx   = m_k - N;
         end else if (m_k < done_offset(m_rows)) begin
            e_drain = 1'b1;
         end else begin
            e_done = e_grant;
         end
      end
      check("req_ready",  req_ready,  e_ready);
      check("grant",      grant,      e_grant);
      check("busy",       busy,       m_busy);
      check("load_en",    load_en,    e_load);
      check("load_row",   load_row,   e_lrow);
      check("stream_en",  stream_en,  e_stream);
      check("stream_idx", stream_idx, e_sidx);
      check("drain",      drain,      e_drain);
      check("done",       done,       e_done);
   endtask

   // Advance the model across one rising edge with the inputs that were applied.
   task automatic model_edge();
      int w;
      m_accepted = 1'b0;
      if (m_busy) begin
         if (m_k == done_offset(m_rows)) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NR;
         end else begin
            m_k++;
         end
      end else begin
         w = pick(req_valid, m_ptr);
         if (w >= 0) begin
            m_busy     = 1'b1;
            m_owner    = w;
            m_rows     = int'(req_rows[w*RW +: RW]);
            m_k        = 0;
            m_accepted = 1'b1;
         end
      end
   endtask

   task automatic step(input logic [NR-1:0] v, input logic [NR*RW-1:0] rows);
      @(negedge clk);
      req_valid = v;
      req_rows  = rows;
      #1;
      compare_all();
      @(posedge clk);
      model_edge();
   endtask

   function automatic logic [NR*RW-1:0] rand_rows();
      logic [NR*RW-1:0] r;
      int sel;
      r = '0;
      for (int i = 0; i < NR; i++) begin
         sel = $urandom_range(0, 7);
         if (sel == 0)      r[i*RW +: RW] = '0;
         else if (sel == 7) r[i*RW +: RW] = RW'($urandom_range(0, 40));
         else               r[i*RW +: RW] = RW'($urandom_range(1, 6));
      end
      return r;
   endfunction

   function automatic logic [NR-1:0] rand_valid();
      logic [NR-1:0] v;
      for (int i = 0; i < NR; i++) v[i] = ($urandom_range(0, 3) != 0);
      return v;
   endfunction

   // Hold a request until n_acc jobs are admitted, then scramble inputs until idle.
   task automatic run_jobs(input logic [NR-1:0] v, input logic [NR*RW-1:0] rows, input int n_acc);
      int got;
      int budget;
      got    = 0;
      budget = 3000;
      while (got < n_acc && budget > 0) begin
         step(v, rows);
         if (m_accepted) got++;
         budget--;
      end
      while (m_busy && budget > 0) begin
         step(rand_valid(), rand_rows());
         budget--;
      end
   endtask

   task automatic reset_between_edges();
      @(negedge clk);
      #2 rst = 1'b1;
      m_busy = 1'b0;
      m_ptr  = 0;
      #1;
      compare_all();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   logic [NR*RW-1:0] rows_v;
   int               budget;

   initial begin
      rst       = 1'b1;
      req_valid = '1;
      req_rows  = '0;
      #3;
      compare_all();
      @(posedge clk);
      #1 rst = 1'b0;

      // Single job from requester 0, five streamed rows.
      rows_v = '0;
      rows_v[0*RW +: RW] = 8'd5;
      run_jobs(2'b01, rows_v, 1);

      // Contention: both requesters held valid, three admissions.
      rows_v = '0;
      rows_v[0*RW +: RW] = 8'd2;
      rows_v[1*RW +: RW] = 8'd3;
      run_jobs(2'b11, rows_v, 3);

      // Zero-length tile.
      rows_v = '0;
      run_jobs(2'b01, rows_v, 1);

      // Maximum row count.
      rows_v = '0;
      rows_v[0*RW +: RW] = 8'd255;
      run_jobs(2'b01, rows_v, 1);

      // Job from requester 0 moves the pointer to 1, then requester 1 is
      // reset in mid-STREAM; afterwards requester 0 must win again.
      rows_v = '0;
      rows_v[0*RW +: RW] = 8'd1;
      rows_v[1*RW +: RW] = 8'd20;
      run_jobs(2'b01, rows_v, 1);
      budget = 200;
      while (!(m_busy && m_k == N + 3) && budget > 0) begin
         step(2'b10, rows_v);
         budget--;
      end
      reset_between_edges();
      run_jobs(2'b11, rows_v, 1);

      // Random traffic: valid toggling and row-count changes at any time.
      for (int c = 0; c < 2500; c++) begin
         step(rand_valid(), rand_rows());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
